// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and defaults for the MEM-stage access unit
package mips_mem_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] aluout;
    logic [4:0]  regwa;
    logic        regwrite;
    logic        memtoreg;
  } memwb_t;

  // Word accesses only: the two low address bits must be zero
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EX/MEM, data-memory and MEM/WB signal bundle
interface mem_access_unit_if;

  logic [31:0] aluout;
  logic [31:0] memwd;
  logic [4:0]  regwa;
  logic        memread;
  logic        memwrite;
  logic        regwrite;
  logic        memtoreg;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        stall;
  logic        err;

  logic [31:0] wb_rdata;
  logic [31:0] wb_aluout;
  logic [4:0]  wb_regwa;
  logic        wb_regwrite;
  logic        wb_memtoreg;

  modport slave (
    input  aluout, memwd, regwa, memread, memwrite, regwrite, memtoreg,
    input  dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output stall, err,
    output wb_rdata, wb_aluout, wb_regwa, wb_regwrite, wb_memtoreg
  );

  modport master (
    output aluout, memwd, regwa, memread, memwrite, regwrite, memtoreg,
    output dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  stall, err,
    input  wb_rdata, wb_aluout, wb_regwa, wb_regwrite, wb_memtoreg
  );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - ACCESS-cycle counter with timeout flag
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  // Count ACCESS cycles; clear wins so a new access always starts from zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expired means this is the last ACCESS cycle the request is allowed
  assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access controller and MEM/WB register
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [1:0]  r_state;
  logic        r_dm_req;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic        r_err;
  memwb_t      r_lat;
  memwb_t      r_wb;

  logic w_is_mem;
  logic w_illegal;
  logic w_legal;
  logic w_expired;

  // Classify the instruction sitting in EX/MEM
  assign w_is_mem  = bus.memread | bus.memwrite;
  assign w_illegal = w_is_mem & (~is_aligned(bus.aluout) | (bus.memread & bus.memwrite));
  assign w_legal   = w_is_mem & ~w_illegal;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state != S_ACCESS),
    .i_inc     (r_state == S_ACCESS),
    .o_expired (w_expired)
  );

  // Freeze the front-end from the detection cycle through the last ACCESS cycle
  always_comb begin
    bus.stall = 1'b0;
    if (r_state == S_ACCESS) begin
      bus.stall = 1'b1;
    end else if (r_state == S_IDLE) begin
      bus.stall = w_legal;
    end
  end

  // Access FSM, memory request registers and MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_err      <= 1'b0;
      r_lat      <= '0;
      r_wb       <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_dm_addr      <= bus.aluout;
            r_dm_wdata     <= bus.memwd;
            r_dm_we        <= bus.memwrite;
            r_dm_req       <= 1'b1;
            r_lat.rdata    <= '0;
            r_lat.aluout   <= bus.aluout;
            r_lat.regwa    <= bus.regwa;
            r_lat.regwrite <= bus.regwrite;
            r_lat.memtoreg <= bus.memtoreg;
            r_wb           <= '0;
            r_state        <= S_ACCESS;
          end else begin
            r_wb.rdata    <= '0;
            r_wb.aluout   <= bus.aluout;
            r_wb.regwa    <= bus.regwa;
            r_wb.regwrite <= bus.regwrite & ~w_illegal;
            r_wb.memtoreg <= bus.memtoreg;
            r_err         <= w_illegal;
          end
        end
        S_ACCESS: begin
          if (bus.dm_ack) begin
            r_lat.rdata <= r_dm_we ? 32'd0 : bus.dm_rdata;
            r_dm_req    <= 1'b0;
            r_state     <= S_DONE;
          end else if (w_expired) begin
            r_lat.rdata    <= '0;
            r_lat.regwrite <= 1'b0;
            r_dm_req       <= 1'b0;
            r_err          <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_wb    <= r_lat;
          r_state <= S_IDLE;
        end
        default: begin
          r_dm_req <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dm_req      = r_dm_req;
  assign bus.dm_we       = r_dm_we;
  assign bus.dm_addr     = r_dm_addr;
  assign bus.dm_wdata    = r_dm_wdata;
  assign bus.err         = r_err;
  assign bus.wb_rdata    = r_wb.rdata;
  assign bus.wb_aluout   = r_wb.aluout;
  assign bus.wb_regwa    = r_wb.regwa;
  assign bus.wb_regwrite = r_wb.regwrite;
  assign bus.wb_memtoreg = r_wb.memtoreg;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   stall_cnt;
  int   req_cnt;
  int   err_cnt;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with stall / dm_req / err high, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.stall === 1'b1) stall_cnt++;
    if (bus.dm_req === 1'b1) req_cnt++;
    if (bus.err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic mw, input logic rw, input logic mtr,
                        input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] wd);
    bus.memread  = mr;
    bus.memwrite = mw;
    bus.regwrite = rw;
    bus.memtoreg = mtr;
    bus.regwa    = wa;
    bus.aluout   = alu;
    bus.memwd    = wd;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0;
    req_cnt   = 0;
    err_cnt   = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_cnt();
    rst = 1'b0;
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);

    // reset state
    tick();
    tick();
    chk("rst_dm_req", bus.dm_req, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_dm_addr", bus.dm_addr, 0);
    chk("rst_wb_aluout", bus.wb_aluout, 0);
    chk("rst_wb_regwrite", bus.wb_regwrite, 0);
    chk("rst_stall", bus.stall, 0);
    rst = 1'b1;

    // ALU pass-through; a stray ack in IDLE must be ignored
    set_in(0, 0, 1, 0, 5'd5, 32'h1234, 32'd0);
    bus.dm_ack = 1'b1;
    #1;
    chk("alu_stall", bus.stall, 0);
    tick();
    bus.dm_ack = 1'b0;
    chk("alu_wb_aluout", bus.wb_aluout, 32'h1234);
    chk("alu_wb_regwa", bus.wb_regwa, 5);
    chk("alu_wb_regwrite", bus.wb_regwrite, 1);
    chk("alu_wb_rdata", bus.wb_rdata, 0);
    chk("alu_dm_req", bus.dm_req, 0);

    // load 0x100, ack in first ACCESS cycle
    clr_cnt();
    set_in(1, 0, 1, 1, 5'd7, 32'h100, 32'd0);
    #1;
    chk("ld_stall_idle", bus.stall, 1);
    tick();
    chk("ld_dm_req", bus.dm_req, 1);
    chk("ld_dm_addr", bus.dm_addr, 32'h100);
    chk("ld_dm_we", bus.dm_we, 0);
    chk("ld_bubble_regwrite", bus.wb_regwrite, 0);
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'hDEADBEEF;
    tick();
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    chk("ld_req_fall", bus.dm_req, 0);
    chk("ld_stall_done", bus.stall, 0);
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("ld_wb_rdata", bus.wb_rdata, 32'hDEADBEEF);
    chk("ld_wb_memtoreg", bus.wb_memtoreg, 1);
    chk("ld_wb_regwrite", bus.wb_regwrite, 1);
    chk("ld_wb_regwa", bus.wb_regwa, 7);
    chk("ld_wb_aluout", bus.wb_aluout, 32'h100);
    chk("ld_stall_cycles", stall_cnt, 2);
    chk("ld_err_cnt", err_cnt, 0);

    // store 0x200 data 0xCAFE, ack in third ACCESS cycle
    clr_cnt();
    set_in(0, 1, 0, 0, 5'd0, 32'h200, 32'hCAFE);
    tick();
    chk("st_dm_we_1", bus.dm_we, 1);
    chk("st_wdata_1", bus.dm_wdata, 32'hCAFE);
    tick();
    chk("st_wdata_2", bus.dm_wdata, 32'hCAFE);
    chk("st_addr_2", bus.dm_addr, 32'h200);
    tick();
    chk("st_wdata_3", bus.dm_wdata, 32'hCAFE);
    chk("st_dm_we_3", bus.dm_we, 1);
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'h5555AAAA;
    tick();
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    chk("st_req_fall", bus.dm_req, 0);
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("st_wb_regwrite", bus.wb_regwrite, 0);
    chk("st_wb_rdata", bus.wb_rdata, 0);
    chk("st_stall_cycles", stall_cnt, 4);
    chk("st_req_cycles", req_cnt, 3);

    // misaligned load
    clr_cnt();
    set_in(1, 0, 1, 1, 5'd3, 32'h102, 32'd0);
    #1;
    chk("mis_stall", bus.stall, 0);
    tick();
    chk("mis_err", bus.err, 1);
    chk("mis_dm_req", bus.dm_req, 0);
    chk("mis_wb_regwrite", bus.wb_regwrite, 0);
    chk("mis_wb_aluout", bus.wb_aluout, 32'h102);
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("mis_err_pulse", bus.err, 0);

    // read and write both set
    set_in(1, 1, 1, 0, 5'd4, 32'h300, 32'h1);
    #1;
    chk("both_stall", bus.stall, 0);
    tick();
    chk("both_err", bus.err, 1);
    chk("both_dm_req", bus.dm_req, 0);
    chk("both_wb_regwrite", bus.wb_regwrite, 0);
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("both_err_pulse", bus.err, 0);
    chk("mis_both_err_cnt", err_cnt, 2);
    chk("mis_both_stall_cnt", stall_cnt, 0);

    // timeout with no ack
    clr_cnt();
    set_in(1, 0, 1, 1, 5'd9, 32'h400, 32'd0);
    tick();
    repeat (15) tick();
    chk("to_last_req", bus.dm_req, 1);
    chk("to_last_err", bus.err, 0);
    tick();
    chk("to_err", bus.err, 1);
    chk("to_req_fall", bus.dm_req, 0);
    chk("to_stall_done", bus.stall, 0);
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("to_err_pulse", bus.err, 0);
    chk("to_wb_regwrite", bus.wb_regwrite, 0);
    chk("to_wb_rdata", bus.wb_rdata, 0);
    chk("to_req_cycles", req_cnt, 16);
    chk("to_err_cnt", err_cnt, 1);

    // ack arrives in the 16th ACCESS cycle: ack wins
    clr_cnt();
    set_in(1, 0, 1, 1, 5'd10, 32'h404, 32'd0);
    tick();
    repeat (15) tick();
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'h12345678;
    tick();
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    chk("ack16_err", bus.err, 0);
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("ack16_wb_rdata", bus.wb_rdata, 32'h12345678);
    chk("ack16_wb_regwrite", bus.wb_regwrite, 1);
    chk("ack16_err_cnt", err_cnt, 0);
    chk("ack16_stall_cycles", stall_cnt, 17);

    // reset during the second ACCESS cycle, then a fresh load
    set_in(1, 0, 1, 1, 5'd11, 32'h500, 32'd0);
    tick();
    tick();
    chk("rstm_req_before", bus.dm_req, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstm_dm_req", bus.dm_req, 0);
    chk("rstm_dm_addr", bus.dm_addr, 0);
    chk("rstm_wb_aluout", bus.wb_aluout, 0);
    chk("rstm_wb_regwa", bus.wb_regwa, 0);
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("rstm_state_idle", bus.stall, 0);
    clr_cnt();
    set_in(1, 0, 1, 1, 5'd12, 32'h600, 32'd0);
    tick();
    chk("fresh_dm_addr", bus.dm_addr, 32'h600);
    tick();
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'hA5A5A5A5;
    tick();
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("fresh_wb_rdata", bus.wb_rdata, 32'hA5A5A5A5);
    chk("fresh_wb_regwa", bus.wb_regwa, 12);
    chk("fresh_wb_regwrite", bus.wb_regwrite, 1);
    chk("fresh_stall_cycles", stall_cnt, 3);
    chk("fresh_err_cnt", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
